// File: rtl/bp_fe_queue_ckpt.sv
// bp_fe_queue_ckpt: FE queue producer end with speculative read and committed checkpoint pointers.
// Ports: clk_i/reset_i (sync active-high); fe_queue_i/fe_queue_v_i/fe_queue_ready_o enqueue side;
//        fe_queue_o/fe_queue_v_o/fe_queue_yumi_i head handshake; fe_queue_clr_i/deq_i/roll_i
//        speculative controls; rs1/rs2 addr+valid decoded from the head instruction.
// Optional: define BP_FE_QUEUE_BYPASS_EN for a zero-latency enqueue-to-head path when empty.
module bp_fe_queue_ckpt #(
  parameter int els_p = 8,
  parameter int width_p = 128,
  parameter int instr_lsb_p = 0,
  parameter int msg_type_bit_p = 127,
  parameter int reg_addr_width_p = 5
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [width_p-1:0]          fe_queue_i,
  input  logic                        fe_queue_v_i,
  output logic                        fe_queue_ready_o,
  output logic [width_p-1:0]          fe_queue_o,
  output logic                        fe_queue_v_o,
  input  logic                        fe_queue_yumi_i,
  input  logic                        fe_queue_clr_i,
  input  logic                        fe_queue_deq_i,
  input  logic                        fe_queue_roll_i,
  output logic [reg_addr_width_p-1:0] rs1_addr_o,
  output logic                        rs1_v_o,
  output logic [reg_addr_width_p-1:0] rs2_addr_o,
  output logic                        rs2_v_o
);
  localparam int aw = $clog2(els_p);
  logic [width_p-1:0] mem [els_p];
  logic [aw:0] wptr, rptr, cptr, cptr_next;
  logic full, read_empty, enq, byp;
  // Occupancy is measured from the checkpoint: consumed-but-uncommitted entries still hold slots.
  assign full = (wptr[aw-1:0] == cptr[aw-1:0]) && (wptr[aw] != cptr[aw]);
  assign read_empty = rptr == wptr;
  assign fe_queue_ready_o = ~full;
  assign enq = fe_queue_v_i & fe_queue_ready_o;
  assign cptr_next = cptr + {{aw{1'b0}}, fe_queue_deq_i};
`ifdef BP_FE_QUEUE_BYPASS_EN
  assign byp = read_empty & enq & ~fe_queue_clr_i & ~fe_queue_roll_i;
`else
  assign byp = 1'b0;
`endif
  assign fe_queue_v_o = ~read_empty | byp;
  assign fe_queue_o = byp ? fe_queue_i : mem[rptr[aw-1:0]];
  assign rs1_addr_o = fe_queue_o[instr_lsb_p+15 +: reg_addr_width_p];
  assign rs2_addr_o = fe_queue_o[instr_lsb_p+20 +: reg_addr_width_p];
  assign rs1_v_o = fe_queue_v_o & fe_queue_o[msg_type_bit_p];
  assign rs2_v_o = rs1_v_o;
  always_ff @(posedge clk_i)
    if (enq & ~fe_queue_clr_i & ~reset_i)
      mem[wptr[aw-1:0]] <= fe_queue_i;
  // clr drops this cycle's enqueue and collapses both read pointers onto the write pointer.
  // roll rewinds the read pointer to the checkpoint including a same-cycle commit.
  always_ff @(posedge clk_i)
    if (reset_i) begin
      wptr <= '0;
      rptr <= '0;
      cptr <= '0;
    end else if (fe_queue_clr_i) begin
      rptr <= wptr;
      cptr <= wptr;
    end else begin
      wptr <= wptr + {{aw{1'b0}}, enq};
      cptr <= cptr_next;
      rptr <= fe_queue_roll_i ? cptr_next : rptr + {{aw{1'b0}}, fe_queue_yumi_i};
    end
  a_deq_legal: assert property (@(posedge clk_i) disable iff (reset_i)
    (fe_queue_deq_i & ~fe_queue_clr_i) |-> (cptr != rptr));
  a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
    fe_queue_yumi_i |-> fe_queue_v_o);
endmodule

// File: tb/tb_bp_fe_queue_ckpt.sv
// tb_bp_fe_queue_ckpt: scoreboard bench for bp_fe_queue_ckpt with els_p=4.
module tb_bp_fe_queue_ckpt;
  typedef logic [127:0] pkt_t;
  logic clk = 0;
  logic reset_i = 1;
  pkt_t fe_queue_i = '0;
  logic fe_queue_v_i = 0, fe_queue_yumi_i = 0, fe_queue_clr_i = 0, fe_queue_deq_i = 0, fe_queue_roll_i = 0;
  logic fe_queue_ready_o, fe_queue_v_o, rs1_v_o, rs2_v_o;
  pkt_t fe_queue_o;
  logic [4:0] rs1_addr_o, rs2_addr_o;
  int n_chk = 0, n_fail = 0;
  pkt_t sb[$];
  pkt_t ck[$];
  bp_fe_queue_ckpt #(.els_p(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .fe_queue_i(fe_queue_i), .fe_queue_v_i(fe_queue_v_i),
    .fe_queue_ready_o(fe_queue_ready_o), .fe_queue_o(fe_queue_o), .fe_queue_v_o(fe_queue_v_o),
    .fe_queue_yumi_i(fe_queue_yumi_i), .fe_queue_clr_i(fe_queue_clr_i), .fe_queue_deq_i(fe_queue_deq_i),
    .fe_queue_roll_i(fe_queue_roll_i), .rs1_addr_o(rs1_addr_o), .rs1_v_o(rs1_v_o),
    .rs2_addr_o(rs2_addr_o), .rs2_v_o(rs2_v_o)
  );
  always #5 clk = ~clk;
  function automatic pkt_t mk(input int n);
    pkt_t p;
    p = '0;
    p[127] = 1'b1;
    p[95:64] = 32'(n) * 32'h9e37;
    p[63:32] = 32'(n);
    p[31:0] = ~32'(n);
    return p;
  endfunction
  task automatic do_reset();
    reset_i = 1;
    sb.delete();
    ck.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_i = 0;
  endtask
  // Drives one cycle of stimulus and advances the reference queues by the intended semantics.
  task automatic cyc(input bit e, input pkt_t d, input bit y, input bit dq, input bit rl, input bit cl);
    fe_queue_v_i = e; fe_queue_i = d; fe_queue_yumi_i = y;
    fe_queue_deq_i = dq; fe_queue_roll_i = rl; fe_queue_clr_i = cl;
    if (cl) begin
      sb.delete();
      ck.delete();
    end else begin
      if (dq) void'(ck.pop_front());
      if (rl) begin
        for (int i = ck.size() - 1; i >= 0; i--) sb.push_front(ck[i]);
        ck.delete();
      end else if (y) ck.push_back(sb.pop_front());
      if (e) sb.push_back(d);
    end
    @(posedge clk); #1;
    fe_queue_v_i = 0; fe_queue_yumi_i = 0; fe_queue_deq_i = 0; fe_queue_roll_i = 0; fe_queue_clr_i = 0;
  endtask
  task automatic test_reset();
    do_reset();
    n_chk += 4;
    if (fe_queue_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", fe_queue_ready_o); end
    if (fe_queue_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_v got %b want 0", fe_queue_v_o); end
    if (rs1_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_rs1_v got %b want 0", rs1_v_o); end
    if (rs2_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_rs2_v got %b want 0", rs2_v_o); end
  endtask
  task automatic test_fill_and_roll();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        n_chk++;
        if (fe_queue_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_ready_before_d got %b want 1", fe_queue_ready_o); end
      end
      cyc(1, mk(i), 0, 0, 0, 0);
      if (i == 0) begin
        n_chk += 2;
        if (fe_queue_v_o !== 1'b1) begin n_fail++; $display("FAIL fill_first_v got %b want 1", fe_queue_v_o); end
        if (fe_queue_o !== mk(0)) begin n_fail++; $display("FAIL fill_first_head got %h want %h", fe_queue_o, mk(0)); end
      end
    end
    n_chk++;
    if (fe_queue_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready got %b want 0", fe_queue_ready_o); end
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (fe_queue_o !== sb[0]) begin n_fail++; $display("FAIL roll_yumi_head got %h want %h", fe_queue_o, sb[0]); end
      cyc(0, '0, 1, 0, 0, 0);
    end
    fe_queue_deq_i = 1;
    #1;
    n_chk++;
    if (fe_queue_ready_o !== 1'b0) begin n_fail++; $display("FAIL deq_no_bypass_ready got %b want 0", fe_queue_ready_o); end
    cyc(0, '0, 0, 1, 0, 0);
    cyc(0, '0, 0, 0, 1, 0);
    n_chk += 4;
    if (fe_queue_o !== mk(1)) begin n_fail++; $display("FAIL roll_head got %h want %h", fe_queue_o, mk(1)); end
    if (fe_queue_o !== sb[0]) begin n_fail++; $display("FAIL roll_head_sb got %h want %h", fe_queue_o, sb[0]); end
    if (fe_queue_v_o !== 1'b1) begin n_fail++; $display("FAIL roll_v got %b want 1", fe_queue_v_o); end
    if (fe_queue_ready_o !== 1'b1) begin n_fail++; $display("FAIL roll_ready got %b want 1", fe_queue_ready_o); end
  endtask
  task automatic test_roll_deq();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, mk(10 + i), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (fe_queue_o !== sb[0]) begin n_fail++; $display("FAIL rolldeq_yumi_head got %h want %h", fe_queue_o, sb[0]); end
      cyc(0, '0, 1, 0, 0, 0);
    end
    cyc(0, '0, 1, 1, 1, 0);
    n_chk += 3;
    if (fe_queue_o !== mk(11)) begin n_fail++; $display("FAIL rolldeq_head got %h want %h", fe_queue_o, mk(11)); end
    if (fe_queue_v_o !== 1'b1) begin n_fail++; $display("FAIL rolldeq_v got %b want 1", fe_queue_v_o); end
    if (fe_queue_ready_o !== 1'b1) begin n_fail++; $display("FAIL rolldeq_ready got %b want 1", fe_queue_ready_o); end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (fe_queue_o !== sb[0]) begin n_fail++; $display("FAIL rolldeq_replay got %h want %h", fe_queue_o, sb[0]); end
      cyc(0, '0, 1, 0, 0, 0);
    end
    n_chk++;
    if (fe_queue_v_o !== 1'b0) begin n_fail++; $display("FAIL rolldeq_drained_v got %b want 0", fe_queue_v_o); end
  endtask
  task automatic test_clr();
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, mk(20 + i), 0, 0, 0, 0);
    cyc(0, '0, 1, 0, 0, 0);
    cyc(1, mk(30), 1, 1, 0, 1);
    n_chk += 2;
    if (fe_queue_v_o !== 1'b0) begin n_fail++; $display("FAIL clr_v got %b want 0", fe_queue_v_o); end
    if (fe_queue_ready_o !== 1'b1) begin n_fail++; $display("FAIL clr_ready got %b want 1", fe_queue_ready_o); end
    cyc(1, mk(31), 0, 0, 0, 0);
    n_chk += 2;
    if (fe_queue_v_o !== 1'b1) begin n_fail++; $display("FAIL clr_f_v got %b want 1", fe_queue_v_o); end
    if (fe_queue_o !== mk(31)) begin n_fail++; $display("FAIL clr_f_head got %h want %h", fe_queue_o, mk(31)); end
    cyc(0, '0, 1, 0, 0, 0);
    n_chk++;
    if (fe_queue_v_o !== 1'b0) begin n_fail++; $display("FAIL clr_e_absent got %b want 0", fe_queue_v_o); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 24; i++) begin
      bit y, dq;
      y = sb.size() != 0;
      dq = ck.size() != 0;
      n_chk += 2;
      if (fe_queue_v_o !== y) begin n_fail++; $display("FAIL stream_v cyc %0d got %b want %b", i, fe_queue_v_o, y); end
      if (fe_queue_ready_o !== 1'b1) begin n_fail++; $display("FAIL stream_ready cyc %0d got %b want 1", i, fe_queue_ready_o); end
      if (y) begin
        n_chk++;
        if (fe_queue_o !== sb[0]) begin n_fail++; $display("FAIL stream_head cyc %0d got %h want %h", i, fe_queue_o, sb[0]); end
      end
      cyc(i < 20, mk(100 + i), y, dq, 0, 0);
    end
  endtask
  task automatic test_rs_decode();
    pkt_t p;
    do_reset();
    p = '0;
    p[127] = 1'b1;
    p[31:0] = 32'h00B50533;
    cyc(1, p, 0, 0, 0, 0);
    n_chk += 4;
    if (rs1_addr_o !== 5'd10) begin n_fail++; $display("FAIL rs1_addr got %0d want 10", rs1_addr_o); end
    if (rs2_addr_o !== 5'd11) begin n_fail++; $display("FAIL rs2_addr got %0d want 11", rs2_addr_o); end
    if (rs1_v_o !== 1'b1) begin n_fail++; $display("FAIL rs1_v_instr got %b want 1", rs1_v_o); end
    if (rs2_v_o !== 1'b1) begin n_fail++; $display("FAIL rs2_v_instr got %b want 1", rs2_v_o); end
    p[127] = 1'b0;
    cyc(1, p, 1, 0, 0, 0);
    n_chk += 3;
    if (rs1_v_o !== 1'b0) begin n_fail++; $display("FAIL rs1_v_exc got %b want 0", rs1_v_o); end
    if (rs2_v_o !== 1'b0) begin n_fail++; $display("FAIL rs2_v_exc got %b want 0", rs2_v_o); end
    if (rs1_addr_o !== 5'd10) begin n_fail++; $display("FAIL rs1_addr_exc got %0d want 10", rs1_addr_o); end
  endtask
  task automatic test_mid_reset();
    do_reset();
    cyc(1, mk(40), 0, 0, 0, 0);
    cyc(1, mk(41), 0, 0, 0, 0);
    reset_i = 1;
    fe_queue_v_i = 1;
    fe_queue_i = mk(42);
    fe_queue_yumi_i = 1;
    @(posedge clk); #1;
    reset_i = 0;
    fe_queue_v_i = 0;
    fe_queue_yumi_i = 0;
    sb.delete();
    ck.delete();
    n_chk += 2;
    if (fe_queue_v_o !== 1'b0) begin n_fail++; $display("FAIL midreset_v got %b want 0", fe_queue_v_o); end
    if (fe_queue_ready_o !== 1'b1) begin n_fail++; $display("FAIL midreset_ready got %b want 1", fe_queue_ready_o); end
  endtask
  initial begin
    test_reset();
    test_fill_and_roll();
    test_roll_deq();
    test_clr();
    test_back_to_back();
    test_rs_decode();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
